mask_row_serializer: RTL and testbench

Downstream of the repeated-pattern generator. Accepts full-width mask rows (one `IMAGE_SENSOR_W`-bit word per row) over a valid/ready handshake and buffers up to two rows. It shifts each row into the sensor's mask shift chain `CHUNK_W` bits per cycle, then pulses a row-load strobe. It tracks the row index within the frame and flags frame completion.

---
 rtl/rp_pkg.sv | 17 +
 rtl/mask_row_fifo.sv | 46 ++++
 rtl/mask_row_serializer.sv | 109 ++++++++++
 tb/tb_mask_row_serializer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rp_pkg.sv
// Shared types and helpers for the mask row path: the serializer FSM state
// and the row counter width used by both the generator and the serializer.
package rp_pkg;

   localparam int ROW_IDX_W = 11;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      LOAD
   } mrs_state_t;

   function automatic int nchunk(input int w, input int c);
      return (w + c - 1) / c;
   endfunction

endpackage

// File: rtl/mask_row_fifo.sv
// Two-entry row buffer between the pattern generator and the shift-chain
// serializer. Flush wins over push and pop in the same cycle.
module mask_row_fifo #(
   parameter int WIDTH = 300
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;

   // NOTE: row storage has no reset; count and pointers decide what is valid,
   // so resetting wide data registers would buy nothing.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         count <= count + 2'(push) - 2'(pop);
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/mask_row_serializer.sv
// Serializes buffered mask rows into the sensor shift chain CHUNK_W bits per
// cycle, strobes the row load, and tracks row position within the frame.
module mask_row_serializer
   import rp_pkg::*;
#(
   parameter int IMAGE_SENSOR_W = 300,
   parameter int IMAGE_SENSOR_H = 300,
   parameter int CHUNK_W        = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clk_en,
   input  logic                      frame_start,
   input  logic [IMAGE_SENSOR_W-1:0] row_mask,
   input  logic                      row_valid,
   output logic                      row_ready,
   output logic [CHUNK_W-1:0]        mask_data,
   output logic                      mask_shift,
   output logic                      mask_load,
   output logic [ROW_IDX_W-1:0]      row_index,
   output logic                      frame_done,
   output logic                      busy
);

   localparam int NCHUNK = nchunk(IMAGE_SENSOR_W, CHUNK_W);
   localparam int PAD_W  = NCHUNK * CHUNK_W;
   localparam int CNT_W  = $clog2(NCHUNK + 1);

   mrs_state_t                state;
   logic [CNT_W-1:0]          chunk_cnt;
   logic [ROW_IDX_W-1:0]      row_idx_q;
   logic [1:0]                count;
   logic [IMAGE_SENSOR_W-1:0] head;
   logic [PAD_W-1:0]          row_pad;
   logic                      push;
   logic                      load_now;
   logic                      last_chunk;
   logic                      last_row;

   assign row_ready  = (count != 2'd2) && clk_en;
   assign push       = row_valid && row_ready && !frame_start;
   // A frame_start landing on the LOAD cycle suppresses that load entirely.
   assign load_now   = (state == LOAD) && clk_en && !frame_start;
   assign last_chunk = (chunk_cnt == CNT_W'(NCHUNK - 1));
   assign last_row   = (row_idx_q == ROW_IDX_W'(IMAGE_SENSOR_H - 1));

   mask_row_fifo #(
      .WIDTH (IMAGE_SENSOR_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (frame_start && clk_en),
      .push  (push),
      .pop   (load_now),
      .din   (row_mask),
      .head  (head),
      .count (count)
   );

   // NOTE: all state updates use non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         chunk_cnt <= '0;
         row_idx_q <= '0;
      end else if (clk_en) begin
         if (frame_start) begin
            state     <= IDLE;
            chunk_cnt <= '0;
            row_idx_q <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (count != 2'd0 || push) begin
                     state     <= SHIFT;
                     chunk_cnt <= '0;
                  end
               end
               SHIFT: begin
                  if (last_chunk) state <= LOAD;
                  else            chunk_cnt <= chunk_cnt + 1'b1;
               end
               LOAD: begin
                  row_idx_q <= last_row ? '0 : row_idx_q + 1'b1;
                  // Occupancy after this pop is count - 1 + push.
                  if (count == 2'd2 || push) begin
                     state     <= SHIFT;
                     chunk_cnt <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Zero-extension supplies the pad bits above the row in the last chunk.
   assign row_pad    = PAD_W'(head);
   assign mask_data  = (state == SHIFT) ? row_pad[chunk_cnt*CHUNK_W +: CHUNK_W] : '0;
   assign mask_shift = (state == SHIFT) && clk_en;
   assign mask_load  = load_now;
   assign frame_done = load_now && last_row;
   assign row_index  = row_idx_q;
   assign busy       = (state != IDLE) || (count != 2'd0);

endmodule

// File: tb/tb_mask_row_serializer.sv
// Directed bench for mask_row_serializer: chunk table plus hand-built
// sequences for backpressure, frame wrap, frame_start, clk_en and reset.
module tb_mask_row_serializer;

   localparam int W   = 300;
   localparam int CW  = 16;
   localparam int NCH = 19;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clk_en;
   logic          frame_start;
   logic [W-1:0]  row_mask;
   logic          row_valid;

   logic          row_ready, mask_shift, mask_load, frame_done, busy;
   logic [CW-1:0] mask_data;
   logic [10:0]   row_index;

   logic          b_row_ready, b_mask_shift, b_mask_load, b_frame_done, b_busy;
   logic [CW-1:0] b_mask_data;
   logic [10:0]   b_row_index;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_idx = 0;

   typedef struct {
      string         name;
      logic [W-1:0]  row;
      logic [CW-1:0] c0;
      logic [CW-1:0] c1;
      logic [CW-1:0] cmid;
      logic [CW-1:0] clast;
   } vec_t;
   vec_t vecs[4];

   int          acc_q[$];
   int          load_q[$];
   logic        rr_q[$];
   logic [15:0] md_q[$];
   logic        fd_a_q[$];
   logic        fd_b_q[$];
   logic [10:0] idx_a_q[$];
   logic [10:0] idx_b_q[$];
   int          fd_b_cnt;

   mask_row_serializer dut (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .frame_start(frame_start),
      .row_mask(row_mask), .row_valid(row_valid), .row_ready(row_ready),
      .mask_data(mask_data), .mask_shift(mask_shift), .mask_load(mask_load),
      .row_index(row_index), .frame_done(frame_done), .busy(busy)
   );

   mask_row_serializer #(.IMAGE_SENSOR_H(4)) dut_h4 (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .frame_start(frame_start),
      .row_mask(row_mask), .row_valid(row_valid), .row_ready(b_row_ready),
      .mask_data(b_mask_data), .mask_shift(b_mask_shift), .mask_load(b_mask_load),
      .row_index(b_row_index), .frame_done(b_frame_done), .busy(b_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      clk_en      = 1'b1;
      frame_start = 1'b0;
      row_valid   = 1'b0;
      row_mask    = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
   endtask

   // One row from idle: 19 shift cycles, load on the 20th cycle after accept.
   task automatic run_vec(input int i);
      logic [CW-1:0] ch[NCH];
      int shifts = 0;
      int mid_bad = 0;
      check({"ready_", vecs[i].name}, row_ready, 1);
      row_valid = 1'b1;
      row_mask  = vecs[i].row;
      tick();
      row_valid = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         if (mask_shift) shifts++;
         ch[k] = mask_data;
         if (k >= 2 && k <= NCH - 2 && mask_data !== vecs[i].cmid) mid_bad++;
         tick();
      end
      check({"shifts_", vecs[i].name}, shifts, NCH);
      check({"chunk0_", vecs[i].name}, ch[0], vecs[i].c0);
      check({"chunk1_", vecs[i].name}, ch[1], vecs[i].c1);
      check({"chunkmid_bad_", vecs[i].name}, mid_bad, 0);
      check({"chunk18_", vecs[i].name}, ch[NCH-1], vecs[i].clast);
      check({"load_", vecs[i].name}, mask_load, 1);
      check({"load_idx_", vecs[i].name}, row_index, exp_idx);
      check({"fdone_", vecs[i].name}, frame_done, 0);
      tick();
      exp_idx++;
      check({"idx_after_", vecs[i].name}, row_index, exp_idx);
      check({"load_off_", vecs[i].name}, mask_load, 0);
      check({"idle_", vecs[i].name}, busy, 0);
   endtask

   // Holds row_valid until n rows are accepted; row i carries 16'h1111*(i+1).
   task automatic feed(input int n, input int budget);
      int  acc = 0;
      logic accept;
      acc_q.delete(); load_q.delete(); rr_q.delete(); md_q.delete();
      fd_a_q.delete(); fd_b_q.delete(); idx_a_q.delete(); idx_b_q.delete();
      fd_b_cnt  = 0;
      row_valid = 1'b1;
      row_mask  = W'(16'h1111);
      for (int c = 0; c < budget; c++) begin
         rr_q.push_back(row_ready);
         md_q.push_back(mask_data);
         if (mask_load) begin
            load_q.push_back(c);
            fd_a_q.push_back(frame_done);
            fd_b_q.push_back(b_frame_done);
            idx_a_q.push_back(row_index);
            idx_b_q.push_back(b_row_index);
         end
         if (b_frame_done) fd_b_cnt++;
         accept = row_valid && row_ready;
         if (accept) acc_q.push_back(c);
         tick();
         if (accept) begin
            acc++;
            if (acc == n) row_valid = 1'b0;
            else          row_mask  = W'(16'h1111 * (acc + 1));
         end
      end
   endtask

   initial begin
      logic [NCH*CW-1:0] wide;
      int bad;
      int loads;

      vecs[0].name = "lsb";  vecs[0].row = W'(1);
      vecs[0].c0 = 16'h0001; vecs[0].c1 = 16'h0000; vecs[0].cmid = 16'h0000; vecs[0].clast = 16'h0000;
      vecs[1].name = "ones"; vecs[1].row = {W{1'b1}};
      vecs[1].c0 = 16'hFFFF; vecs[1].c1 = 16'hFFFF; vecs[1].cmid = 16'hFFFF; vecs[1].clast = 16'h0FFF;
      vecs[2].name = "mixed"; vecs[2].row = (W'(12'hABC) << 288) | W'(32'h1234_5678);
      vecs[2].c0 = 16'h5678; vecs[2].c1 = 16'h1234; vecs[2].cmid = 16'h0000; vecs[2].clast = 16'h0ABC;
      vecs[3].name = "msb";  vecs[3].row = W'(1) << (W - 1);
      vecs[3].c0 = 16'h0000; vecs[3].c1 = 16'h0000; vecs[3].cmid = 16'h0000; vecs[3].clast = 16'h0800;

      do_reset();
      check("rst_row_ready", row_ready, 1);
      check("rst_mask_data", mask_data, 0);
      check("rst_mask_shift", mask_shift, 0);
      check("rst_mask_load", mask_load, 0);
      check("rst_row_index", row_index, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_busy", busy, 0);

      for (int i = 0; i < 4; i++) run_vec(i);

      // Three rows with valid held: ready drops at 2, third accepted after first load.
      feed(3, 62);
      check("b2b_nacc", acc_q.size(), 3);
      check("b2b_acc0", acc_q[0], 0);
      check("b2b_acc1", acc_q[1], 1);
      check("b2b_acc2", acc_q[2], 21);
      check("b2b_nload", load_q.size(), 3);
      check("b2b_load0", load_q[0], 20);
      check("b2b_load1", load_q[1], 40);
      check("b2b_load2", load_q[2], 60);
      check("b2b_ready_full", rr_q[2], 0);
      check("b2b_ready_at_load", rr_q[20], 0);
      check("b2b_ready_after_load", rr_q[21], 1);
      check("b2b_row1_chunk0", md_q[21], 16'h2222);
      check("b2b_row2_chunk0", md_q[41], 16'h3333);

      // Push during LOAD with one row buffered: count stays 1, no bubble.
      row_valid = 1'b1; row_mask = vecs[0].row;
      tick();
      row_valid = 1'b0;
      repeat (19) tick();
      check("pp_load", mask_load, 1);
      row_valid = 1'b1; row_mask = W'(16'h5555);
      tick();
      row_valid = 1'b0;
      check("pp_shift", mask_shift, 1);
      check("pp_chunk0", mask_data, 16'h5555);
      check("pp_ready", row_ready, 1);
      repeat (19) tick();
      check("pp_load2", mask_load, 1);
      tick();
      check("pp_idle", busy, 0);

      // frame_start at chunk 7 with two rows buffered.
      row_valid = 1'b1; row_mask = vecs[1].row;
      tick();
      row_mask = vecs[2].row;
      tick();
      row_valid = 1'b0;
      repeat (6) tick();
      check("fs_chunk7", mask_data, 16'hFFFF);
      check("fs_ready_full", row_ready, 0);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      check("fs_busy", busy, 0);
      check("fs_row_index", row_index, 0);
      check("fs_shift", mask_shift, 0);
      loads = 0;
      for (int c = 0; c < 25; c++) begin
         if (mask_load) loads++;
         tick();
      end
      check("fs_no_load", loads, 0);
      exp_idx = 0;
      run_vec(2);

      // frame_start on the LOAD cycle: load suppressed, index cleared.
      row_valid = 1'b1; row_mask = vecs[0].row;
      tick();
      row_valid = 1'b0;
      repeat (19) tick();
      check("fsl_load_pending", mask_load, 1);
      frame_start = 1'b1;
      #1;
      check("fsl_load_gated", mask_load, 0);
      check("fsl_fdone_gated", frame_done, 0);
      tick();
      frame_start = 1'b0;
      check("fsl_row_index", row_index, 0);
      check("fsl_busy", busy, 0);

      // clk_en low for 5 cycles at chunk 10.
      for (int k = 0; k < NCH; k++) wide[k*CW +: CW] = 16'hA000 + 16'(k);
      row_valid = 1'b1; row_mask = wide[W-1:0];
      tick();
      row_valid = 1'b0;
      repeat (10) tick();
      check("ce_chunk10", mask_data, 16'hA00A);
      clk_en = 1'b0;
      #1;
      bad = 0;
      for (int j = 0; j < 5; j++) begin
         if (mask_shift || mask_load || mask_data !== 16'hA00A) bad++;
         tick();
      end
      check("ce_frozen_bad", bad, 0);
      clk_en = 1'b1;
      #1;
      bad = 0;
      for (int k = 10; k < NCH; k++) begin
         if (!mask_shift) bad++;
         if (mask_data !== ((k == NCH - 1) ? 16'h0012 : 16'hA000 + 16'(k))) bad++;
         tick();
      end
      check("ce_resume_bad", bad, 0);
      check("ce_load_late", mask_load, 1);

      // Frame of 4 rows on the H=4 instance; 5th row wraps to index 0.
      do_reset();
      feed(5, 110);
      check("h4_nload", load_q.size(), 5);
      check("h4_load4_cyc", load_q[3], 80);
      check("h4_fd_load3", fd_b_q[2], 0);
      check("h4_fd_load4", fd_b_q[3], 1);
      check("h4_fd_load5", fd_b_q[4], 0);
      check("h4_fd_count", fd_b_cnt, 1);
      check("h4_idx_load4", idx_b_q[3], 3);
      check("h4_idx_load5", idx_b_q[4], 0);
      check("h300_fd_load4", fd_a_q[3], 0);
      check("h300_idx_load5", idx_a_q[4], 4);

      // Reset mid-row aborts the row without a load.
      row_valid = 1'b1; row_mask = vecs[1].row;
      tick();
      row_valid = 1'b0;
      repeat (5) tick();
      rst_n = 1'b0;
      #1;
      check("rmid_shift", mask_shift, 0);
      check("rmid_busy", busy, 0);
      #1;
      rst_n = 1'b1;
      loads = 0;
      for (int c = 0; c < 30; c++) begin
         if (mask_load) loads++;
         tick();
      end
      check("rmid_no_load", loads, 0);
      check("rmid_idle", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
